gmii_tx: RTL and testbench

GMII_TX -- requirements
Module: gmii_tx

---
 rtl/gmii_tx_pkg.sv | 24 ++
 rtl/gmii_tx_cnt.sv | 35 +++
 rtl/gmii_tx.sv | 140 ++++++++++++++
 tb/tb_gmii_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_pkg.sv
// GMII transmit definitions: state codes, framing bytes, length limit.
// Kept separate so the receive side can share the same constants.
package gmii_tx_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREA = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_BODY = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;
    localparam logic [2:0] ST_IFG  = 3'd5;

    localparam logic [7:0]  PREA_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [10:0] BCNT_MAX  = 11'd2047;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
    } gmii_t;

endpackage

// File: rtl/gmii_tx_cnt.sv
// Loadable down-counter used to time preamble and inter-frame gap.
// Saturates at zero so an idle decrement cannot wrap.
module gmii_tx_cnt
    import gmii_tx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gmii_tx.sv
// GMII transmitter: preamble, SFD, FIFO-fed body, underrun/overflow drop, IFG.
// Line outputs come straight from flops; FIFO_REN is decoded from state.
module gmii_tx
    import gmii_tx_pkg::*;
#(
    parameter int PREA_LEN = 7,
    parameter int IFG_LEN  = 12
) (
    input  logic        ARSTN,
    input  logic        TCLK,
    output logic [7:0]  TXD,
    output logic        TXEN,
    output logic        TXER,
    input  logic [7:0]  FIFO_RDAT,
    input  logic        FIFO_REOD,
    output logic        FIFO_REN,
    input  logic        FIFO_EMPTY,
    input  logic        FIFO_PRDY,
    output logic [10:0] TX_BCNT,
    output logic        TX_UNDR
);

    localparam logic [CNT_W-1:0] PREA_LD = CNT_W'(PREA_LEN - 1);
    // The IDLE cycle that follows IFG supplies the last low cycle of the gap.
    localparam logic [CNT_W-1:0] IFG_LD  = CNT_W'(IFG_LEN - 2);

    logic [2:0]       state_q, state_d;
    logic             pend_q;
    logic [10:0]      bcnt_q, bcnt_d;
    logic             undr_q, undr_d;
    gmii_t            tx_q, tx_d;
    logic             ren, eod;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    gmii_tx_cnt u_cnt (
        .clk_i  (TCLK),
        .rst_ni (ARSTN),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    assign eod = pend_q && FIFO_REOD;

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        undr_d   = 1'b0;
        tx_d     = '0;
        ren      = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (FIFO_PRDY) begin
                    state_d  = ST_PREA;
                    bcnt_d   = '0;
                    cnt_load = 1'b1;
                    cnt_val  = PREA_LD;
                end
            end
            ST_PREA: begin
                tx_d.en = 1'b1;
                tx_d.d  = PREA_BYTE;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                tx_d.en = 1'b1;
                tx_d.d  = SFD_BYTE;
                ren     = !FIFO_EMPTY;
                state_d = ST_BODY;
            end
            ST_BODY: begin
                ren     = !FIFO_EMPTY && !eod;
                tx_d.en = 1'b1;
                // No byte arrived for this slot, or the length limit is hit.
                if (!pend_q || bcnt_q == BCNT_MAX) begin
                    tx_d.er = 1'b1;
                    undr_d  = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    tx_d.d = FIFO_RDAT;
                    bcnt_d = bcnt_q + 11'd1;
                end
                if (eod) begin
                    state_d  = ST_IFG;
                    cnt_load = 1'b1;
                    cnt_val  = IFG_LD;
                end
            end
            ST_DROP: begin
                ren = !FIFO_EMPTY && !eod;
                if (eod) begin
                    state_d  = ST_IFG;
                    cnt_load = 1'b1;
                    cnt_val  = IFG_LD;
                end
            end
            ST_IFG: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge TCLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            bcnt_q  <= '0;
            undr_q  <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= ren;
            bcnt_q  <= bcnt_d;
            undr_q  <= undr_d;
            tx_q    <= tx_d;
        end
    end

    assign TXD      = tx_q.d;
    assign TXEN     = tx_q.en;
    assign TXER     = tx_q.er;
    assign FIFO_REN = ren;
    assign TX_BCNT  = bcnt_q;
    assign TX_UNDR  = undr_q;

endmodule

// File: tb/tb_gmii_tx.sv
// Directed bench for gmii_tx: packet table plus reset and back-to-back cases.
// A small FIFO model feeds the DUT; a line monitor decodes each frame.
module tb_gmii_tx;

    localparam int PREA = 7;
    localparam int IFG  = 12;

    logic        ARSTN = 1'b1;
    logic        TCLK  = 1'b0;
    logic [7:0]  TXD;
    logic        TXEN, TXER;
    logic [7:0]  FIFO_RDAT;
    logic        FIFO_REOD;
    logic        FIFO_REN;
    logic        FIFO_EMPTY, FIFO_PRDY;
    logic [10:0] TX_BCNT;
    logic        TX_UNDR;

    gmii_tx #(.PREA_LEN(PREA), .IFG_LEN(IFG)) dut (
        .ARSTN      (ARSTN),
        .TCLK       (TCLK),
        .TXD        (TXD),
        .TXEN       (TXEN),
        .TXER       (TXER),
        .FIFO_RDAT  (FIFO_RDAT),
        .FIFO_REOD  (FIFO_REOD),
        .FIFO_REN   (FIFO_REN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_PRDY  (FIFO_PRDY),
        .TX_BCNT    (TX_BCNT),
        .TX_UNDR    (TX_UNDR)
    );

    always #5 TCLK = ~TCLK;

    // FIFO model with one-cycle read latency
    logic [7:0] mem_d [0:4095];
    logic       mem_e [0:4095];
    int         wr = 0, rd = 0, pk_wr = 0, pk_rd = 0;
    int         stall_idx = -1;
    bit         stall_on = 0, flush = 0;
    logic [7:0] rdat = '0;
    logic       reod = 1'b0;
    int         npkt = 0;

    assign FIFO_EMPTY = (rd == wr) || (stall_on && rd == stall_idx);
    assign FIFO_PRDY  = (pk_wr != pk_rd);
    assign FIFO_RDAT  = rdat;
    assign FIFO_REOD  = reod;

    always @(posedge TCLK) begin
        if (flush) begin
            rd    <= wr;
            pk_rd <= pk_wr;
        end else if (FIFO_REN && !FIFO_EMPTY) begin
            rdat <= mem_d[rd[11:0]];
            reod <= mem_e[rd[11:0]];
            rd   <= rd + 1;
            if (mem_e[rd[11:0]]) pk_rd <= pk_rd + 1;
        end
    end

    function automatic logic [7:0] pat(int p, int i);
        int v;
        v = (p * 29 + i * 7 + 3) & 255;
        return v[7:0];
    endfunction

    task automatic push(int len);
        for (int i = 0; i < len; i++) begin
            mem_d[wr[11:0]] = pat(npkt, i);
            mem_e[wr[11:0]] = (i == len - 1);
            wr = wr + 1;
        end
        pk_wr = pk_wr + 1;
        npkt  = npkt + 1;
    endtask

    // Line monitor
    int frames = 0, pre_cnt = 0, body = 0, bad = 0, errc = 0, undr = 0;
    int low_run = 0, last_gap = 0;
    bit sfd = 0, prev_en = 0;

    initial forever begin
        @(negedge TCLK);
        if (!ARSTN) begin
            prev_en = 0;
        end else begin
            if (TXEN) begin
                if (!prev_en) begin
                    frames   = frames + 1;
                    last_gap = low_run;
                    pre_cnt  = 0;
                    sfd      = 0;
                    body     = 0;
                    bad      = 0;
                    errc     = 0;
                    undr     = 0;
                end
                if (!sfd) begin
                    if (TXD == 8'h55 && !TXER) pre_cnt = pre_cnt + 1;
                    else if (TXD == 8'hD5 && !TXER) sfd = 1;
                    else bad = bad + 1;
                end else if (TXER) begin
                    errc = errc + 1;
                    if (TXD != 8'h00) bad = bad + 1;
                end else begin
                    if (TXD != pat(frames - 1, body)) bad = bad + 1;
                    body = body + 1;
                end
                low_run = 0;
            end else begin
                if (TXER || TXD != 8'h00) bad = bad + 1;
                low_run = low_run + 1;
            end
            if (TX_UNDR) undr = undr + 1;
            prev_en = TXEN;
        end
    end

    int nvec = 0, nmis = 0;

    task automatic check(string name, int act, int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nmis = nmis + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int stall;
        int body;
        int err;
        int bcnt;
    } vec_t;

    vec_t tbl [7];

    task automatic run_vec(string tag, vec_t v);
        int f0;
        bit done;
        f0   = frames;
        done = 0;
        if (v.stall >= 0) begin
            stall_idx = wr + v.stall;
            stall_on  = 1;
        end
        push(v.len);
        for (int c = 0; c < 8000; c++) begin
            @(negedge TCLK);
            #1;
            if (errc > 0 && frames == f0 + 1) stall_on = 0;
            if (frames == f0 + 1 && rd == wr && low_run >= IFG + 2) begin
                done = 1;
                break;
            end
        end
        stall_on = 0;
        check({tag, " done"}, int'(done), 1);
        check({tag, " preamble"}, pre_cnt, PREA);
        check({tag, " sfd"}, int'(sfd), 1);
        check({tag, " body"}, body, v.body);
        check({tag, " data"}, bad, 0);
        check({tag, " err"}, errc, v.err);
        check({tag, " undr"}, undr, v.err);
        check({tag, " bcnt"}, int'(TX_BCNT), v.bcnt);
    endtask

    initial begin
        int f0, hi;
        bit ok;
        vec_t v;

        tbl[0] = '{len: 60,   stall: -1, body: 60,   err: 0, bcnt: 60};
        tbl[1] = '{len: 1,    stall: -1, body: 1,    err: 0, bcnt: 1};
        tbl[2] = '{len: 30,   stall: 10, body: 10,   err: 1, bcnt: 10};
        tbl[3] = '{len: 12,   stall: 0,  body: 0,    err: 1, bcnt: 0};
        tbl[4] = '{len: 2047, stall: -1, body: 2047, err: 0, bcnt: 2047};
        tbl[5] = '{len: 2048, stall: -1, body: 2047, err: 1, bcnt: 2047};
        tbl[6] = '{len: 2100, stall: -1, body: 2047, err: 1, bcnt: 2047};

        #1 ARSTN = 1'b0;
        repeat (3) @(negedge TCLK);
        #1;
        check("rst TXD", int'(TXD), 0);
        check("rst TXEN", int'(TXEN), 0);
        check("rst TXER", int'(TXER), 0);
        check("rst REN", int'(FIFO_REN), 0);
        check("rst BCNT", int'(TX_BCNT), 0);
        check("rst UNDR", int'(TX_UNDR), 0);
        @(negedge TCLK);
        ARSTN = 1'b1;

        hi = 0;
        repeat (8) begin
            @(negedge TCLK);
            #1;
            if (TXEN) hi = hi + 1;
        end
        check("idle hold", hi, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Two queued 64-byte packets: gap must be exactly IFG
        f0 = frames;
        ok = 0;
        push(64);
        push(64);
        for (int c = 0; c < 2000; c++) begin
            @(negedge TCLK);
            #1;
            if (frames == f0 + 2 && rd == wr && low_run >= IFG + 2) begin
                ok = 1;
                break;
            end
        end
        check("b2b done", int'(ok), 1);
        check("b2b gap", last_gap, IFG);
        check("b2b body", body, 64);
        check("b2b data", bad, 0);
        check("b2b bcnt", int'(TX_BCNT), 64);

        // Reset during body byte 20
        f0 = frames;
        ok = 0;
        push(40);
        for (int c = 0; c < 500; c++) begin
            @(negedge TCLK);
            #1;
            if (frames == f0 + 1 && body == 20) begin
                ok = 1;
                break;
            end
        end
        check("mid reach", int'(ok), 1);
        ARSTN = 1'b0;
        #1;
        check("mid TXEN", int'(TXEN), 0);
        check("mid TXD", int'(TXD), 0);
        check("mid TXER", int'(TXER), 0);
        check("mid REN", int'(FIFO_REN), 0);
        check("mid BCNT", int'(TX_BCNT), 0);
        check("mid UNDR", int'(TX_UNDR), 0);
        flush = 1;
        @(posedge TCLK);
        #1 flush = 0;
        @(negedge TCLK);
        ARSTN = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge TCLK);
            #1;
            if (TXEN) hi = hi + 1;
        end
        check("post rst idle", hi, 0);
        v = '{len: 5, stall: -1, body: 5, err: 0, bcnt: 5};
        run_vec("post rst", v);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
